// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: external-port FSM states and
// the per-cycle grant owner of the single memory port.
package dmem_arb_pkg;

    // External requester protocol state
    typedef enum logic [1:0] {
        EXT_IDLE   = 2'd0,
        EXT_ACCESS = 2'd1,
        EXT_RSP    = 2'd2
    } ext_state_t;

    // Which requester drives the memory port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_EXT  = 2'd2
    } grant_t;

    localparam int EXT_STATE_W = 2;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating counter of consecutive cycles in which a waiting external
// request lost to the core. 'sat' forces the next external grant.
module dmem_arb_starve_ctr #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign sat = (cnt == CW'(LIMIT));

    // Count blocked cycles, clear on accept or withdrawal, hold at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory. The core
// load/store path has priority; an external valid/ready port (debug/DMA)
// gets the memory when the core is idle. With DMEM_ARB_STARVE_EN defined
// a starvation counter forces one external grant after STARVE_LIMIT
// blocked cycles; otherwise the core has strict priority.
//
// Handshake: a transfer happens on a channel in any cycle where both its
// valid and ready are high. ext_req_ready is combinational and never
// waits on ext_rsp_ready; ext_rsp_valid is registered and, once high,
// holds with ext_rdata stable until ext_rsp_ready is seen.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int SIZE         = 256,
    parameter int NUM_COL      = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int LOGSIZE     = $clog2(SIZE),
    localparam int AW          = LOGSIZE + 2
) (
    input  logic               clk,
    input  logic               reset,
    // core load/store path
    input  logic               core_req,
    input  logic [AW-1:0]      core_addr,
    input  logic [WIDTH-1:0]   core_wdata,
    input  logic [NUM_COL-1:0] core_be,
    output logic               core_stall,
    output logic               core_rvalid,
    output logic [WIDTH-1:0]   core_rdata,
    // external request channel
    input  logic               ext_req_valid,
    output logic               ext_req_ready,
    input  logic               ext_we,
    input  logic [AW-1:0]      ext_addr,
    input  logic [WIDTH-1:0]   ext_wdata,
    input  logic [NUM_COL-1:0] ext_wstrb,
    // external response channel
    output logic               ext_rsp_valid,
    input  logic               ext_rsp_ready,
    output logic [WIDTH-1:0]   ext_rdata,
    // memory port
    output logic [LOGSIZE-1:0] mem_word_addr,
    output logic [WIDTH-1:0]   mem_data_in,
    output logic [NUM_COL-1:0] mem_byte_wr_en,
    input  logic [WIDTH-1:0]   mem_data_out,
    // debug view of the external FSM
    output logic [EXT_STATE_W-1:0] ext_state_dbg
);

    ext_state_t ext_state;
    logic       ext_we_q;
    logic       force_ext;
    logic       grant_ext;
    logic       ext_idle;
    grant_t     gnt;

    assign ext_idle  = (ext_state == EXT_IDLE);
    assign grant_ext = ext_idle && ext_req_valid && (!core_req || force_ext);

    assign core_stall    = core_req && grant_ext;
    assign ext_req_ready = grant_ext;
    assign core_rdata    = mem_data_out;
    assign ext_state_dbg = ext_state;

`ifdef DMEM_ARB_STARVE_EN
    logic starve_inc;
    logic starve_clr;

    assign starve_inc = ext_idle && ext_req_valid && core_req && !grant_ext;
    assign starve_clr = grant_ext || (ext_idle && !ext_req_valid);

    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (force_ext)
    );
`else
    // Strict core priority: the external port only wins on idle core cycles
    assign force_ext = 1'b0;

    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_LIMIT < 0);
`endif

    // Byte-offset bits of both addresses are ignored (word-addressed memory)
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr[1:0], ext_addr[1:0]};

    // Pick the port owner and drive the memory; address defaults to the core
    always_comb begin
        gnt            = GNT_NONE;
        mem_word_addr  = core_addr[AW-1:2];
        mem_data_in    = core_wdata;
        mem_byte_wr_en = '0;
        if (grant_ext) begin
            gnt = GNT_EXT;
        end else if (core_req) begin
            gnt = GNT_CORE;
        end
        case (gnt)
            GNT_CORE: begin
                mem_byte_wr_en = core_be;
            end
            GNT_EXT: begin
                mem_word_addr  = ext_addr[AW-1:2];
                mem_data_in    = ext_wdata;
                mem_byte_wr_en = ext_we ? ext_wstrb : '0;
            end
            default: begin
            end
        endcase
    end

    // Core read data is valid the cycle after a granted core read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rvalid <= 1'b0;
        end else begin
            core_rvalid <= core_req && (core_be == '0) && !grant_ext;
        end
    end

    // External FSM: accept, wait for registered read data, hold response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_state     <= EXT_IDLE;
            ext_we_q      <= 1'b0;
            ext_rsp_valid <= 1'b0;
            ext_rdata     <= '0;
        end else begin
            case (ext_state)
                EXT_IDLE: begin
                    if (grant_ext) begin
                        ext_state <= EXT_ACCESS;
                        // the requester may change ext_we after the accept
                        ext_we_q  <= ext_we;
                    end
                end
                EXT_ACCESS: begin
                    ext_state     <= EXT_RSP;
                    ext_rsp_valid <= 1'b1;
                    ext_rdata     <= ext_we_q ? '0 : mem_data_out;
                end
                EXT_RSP: begin
                    if (ext_rsp_ready) begin
                        ext_state     <= EXT_IDLE;
                        ext_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    ext_state     <= EXT_IDLE;
                    ext_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural registered-output
// memory. Inputs change on the falling edge; combinational outputs are
// checked 1 ns later, registered outputs at the next falling edge.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 256;
    localparam int NUM_COL = 4;
    localparam int LOGSIZE = 8;
    localparam int AW      = 10;

    logic               clk;
    logic               reset;
    logic               core_req;
    logic [AW-1:0]      core_addr;
    logic [WIDTH-1:0]   core_wdata;
    logic [NUM_COL-1:0] core_be;
    logic               core_stall;
    logic               core_rvalid;
    logic [WIDTH-1:0]   core_rdata;
    logic               ext_req_valid;
    logic               ext_req_ready;
    logic               ext_we;
    logic [AW-1:0]      ext_addr;
    logic [WIDTH-1:0]   ext_wdata;
    logic [NUM_COL-1:0] ext_wstrb;
    logic               ext_rsp_valid;
    logic               ext_rsp_ready;
    logic [WIDTH-1:0]   ext_rdata;
    logic [LOGSIZE-1:0] mem_word_addr;
    logic [WIDTH-1:0]   mem_data_in;
    logic [NUM_COL-1:0] mem_byte_wr_en;
    logic [WIDTH-1:0]   mem_data_out = '0;
    logic [1:0]         ext_state_dbg;

    logic [WIDTH-1:0] mem [0:SIZE-1] = '{default: '0};

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_v;

    dmem_arbiter #(
        .WIDTH        (WIDTH),
        .SIZE         (SIZE),
        .NUM_COL      (NUM_COL),
        .STARVE_LIMIT (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .core_req       (core_req),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_be        (core_be),
        .core_stall     (core_stall),
        .core_rvalid    (core_rvalid),
        .core_rdata     (core_rdata),
        .ext_req_valid  (ext_req_valid),
        .ext_req_ready  (ext_req_ready),
        .ext_we         (ext_we),
        .ext_addr       (ext_addr),
        .ext_wdata      (ext_wdata),
        .ext_wstrb      (ext_wstrb),
        .ext_rsp_valid  (ext_rsp_valid),
        .ext_rsp_ready  (ext_rsp_ready),
        .ext_rdata      (ext_rdata),
        .mem_word_addr  (mem_word_addr),
        .mem_data_in    (mem_data_in),
        .mem_byte_wr_en (mem_byte_wr_en),
        .mem_data_out   (mem_data_out),
        .ext_state_dbg  (ext_state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // single-port memory: byte-enable write, registered read-before-write
    always @(posedge clk) begin
        for (int i = 0; i < NUM_COL; i++) begin
            if (mem_byte_wr_en[i]) mem[mem_word_addr][8*i +: 8] <= mem_data_in[8*i +: 8];
        end
        mem_data_out <= mem[mem_word_addr];
    end

    // driver tasks
    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        core_req      = 1'b0;
        core_addr     = '0;
        core_wdata    = '0;
        core_be       = '0;
        ext_req_valid = 1'b0;
        ext_we        = 1'b0;
        ext_addr      = '0;
        ext_wdata     = '0;
        ext_wstrb     = '0;
        ext_rsp_ready = 1'b0;
    endtask

    task automatic core_drive(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [NUM_COL-1:0] be);
        core_req   = 1'b1;
        core_addr  = a;
        core_wdata = d;
        core_be    = be;
    endtask

    task automatic ext_drive(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [NUM_COL-1:0] s);
        ext_req_valid = 1'b1;
        ext_we        = we;
        ext_addr      = a;
        ext_wdata     = d;
        ext_wstrb     = s;
    endtask

    // scoreboard: compare a presented response with the oldest expectation
    task automatic check_rsp(input string tag);
        check({tag, "_valid"}, ext_rsp_valid, 1'b1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            exp_v = exp_q.pop_front();
            check({tag, "_rdata"}, ext_rdata, exp_v);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_core_rvalid", core_rvalid, 1'b0);
        check("rst_rsp_valid", ext_rsp_valid, 1'b0);
        check("rst_ext_rdata", ext_rdata, 32'h0);
        check("rst_state", ext_state_dbg, EXT_IDLE);
        check("rst_req_ready", ext_req_ready, 1'b0);
        check("rst_core_stall", core_stall, 1'b0);
        check("rst_byte_wr_en", mem_byte_wr_en, 4'h0);
        reset = 1'b0;

        // core write word 5 then read it back
        core_drive(10'h014, 32'hDEADBEEF, 4'hF);
        #1;
        check("cw_be", mem_byte_wr_en, 4'hF);
        check("cw_addr", mem_word_addr, 8'd5);
        check("cw_stall", core_stall, 1'b0);
        @(negedge clk);
        check("cw_no_rvalid", core_rvalid, 1'b0);
        core_drive(10'h014, 32'h0, 4'h0);
        #1;
        check("cr_be", mem_byte_wr_en, 4'h0);
        @(negedge clk);
        check("cr_rvalid", core_rvalid, 1'b1);
        check("cr_rdata", core_rdata, 32'hDEADBEEF);

        // partial core write word 3, read back
        core_drive(10'h00C, 32'hAABBCCDD, 4'b0011);
        #1;
        check("cpw_be", mem_byte_wr_en, 4'b0011);
        @(negedge clk);
        core_drive(10'h00C, 32'h0, 4'h0);
        @(negedge clk);
        check("cpr_rvalid", core_rvalid, 1'b1);
        check("cpr_rdata", core_rdata, 32'h0000CCDD);
        core_req = 1'b0;
        @(negedge clk);
        check("core_idle_rvalid", core_rvalid, 1'b0);

        // external write word 8, strobes 0101 over zero
        ext_drive(1'b1, 10'h020, 32'h12345678, 4'b0101);
        #1;
        check("ew_ready", ext_req_ready, 1'b1);
        check("ew_addr", mem_word_addr, 8'd8);
        check("ew_be", mem_byte_wr_en, 4'b0101);
        exp_q.push_back(32'h0);
        @(negedge clk);
        ext_req_valid = 1'b0;
        check("ew_t1_rsp_valid", ext_rsp_valid, 1'b0);
        check("ew_t1_state", ext_state_dbg, EXT_ACCESS);
        @(negedge clk);
        check_rsp("ew_rsp");
        ext_rsp_ready = 1'b1;
        @(negedge clk);
        check("ew_rsp_done", ext_rsp_valid, 1'b0);
        ext_rsp_ready = 1'b0;

        // external read word 8; ext_we toggles after accept and must not matter
        ext_drive(1'b0, 10'h020, 32'h0, 4'h0);
        #1;
        check("er_ready", ext_req_ready, 1'b1);
        check("er_be", mem_byte_wr_en, 4'h0);
        exp_q.push_back(32'h00340078);
        @(negedge clk);
        ext_req_valid = 1'b0;
        ext_we        = 1'b1;
        @(negedge clk);
        check_rsp("er_rsp");

        // response backpressure for 5 cycles while core reads proceed
        ext_drive(1'b0, 10'h014, 32'h0, 4'h0);
        core_drive(10'h014, 32'h0, 4'h0);
        #1;
        check("bp0_req_ready", ext_req_ready, 1'b0);
        check("bp0_stall", core_stall, 1'b0);
        check("bp0_addr", mem_word_addr, 8'd5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", ext_rsp_valid, 1'b1);
            check("bp_rdata_stable", ext_rdata, 32'h00340078);
            check("bp_req_ready", ext_req_ready, 1'b0);
            check("bp_stall", core_stall, 1'b0);
            check("bp_core_rvalid", core_rvalid, 1'b1);
            check("bp_core_rdata", core_rdata, 32'hDEADBEEF);
        end

        // asynchronous reset while in EXT_RSP drops outputs without an edge
        #3;
        reset = 1'b1;
        #1;
        check("ar_rsp_valid", ext_rsp_valid, 1'b0);
        check("ar_core_rvalid", core_rvalid, 1'b0);
        check("ar_state", ext_state_dbg, EXT_IDLE);
        check("ar_ext_rdata", ext_rdata, 32'h0);
        void'(exp_q.pop_front());
        @(negedge clk);
        core_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_post_ready", ext_req_ready, 1'b1);
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        ext_req_valid = 1'b0;
        @(negedge clk);
        check_rsp("ar_post_rsp");
        ext_rsp_ready = 1'b1;
        @(negedge clk);
        check("ar_post_done", ext_rsp_valid, 1'b0);
        ext_rsp_ready = 1'b0;

`ifdef DMEM_ARB_STARVE_EN
        // starvation: forced grant on the 9th blocked cycle
        core_drive(10'h014, 32'h0, 4'h0);
        ext_drive(1'b0, 10'h020, 32'h0, 4'h0);
        for (int k = 1; k <= 8; k++) begin
            #1;
            check("sv_wait_ready", ext_req_ready, 1'b0);
            check("sv_wait_stall", core_stall, 1'b0);
            @(negedge clk);
        end
        #1;
        check("sv_force_ready", ext_req_ready, 1'b1);
        check("sv_force_stall", core_stall, 1'b1);
        check("sv_force_addr", mem_word_addr, 8'd8);
        check("sv_force_be", mem_byte_wr_en, 4'h0);
        exp_q.push_back(32'h00340078);
        @(negedge clk);
        ext_req_valid = 1'b0;
        #1;
        check("sv_replay_stall", core_stall, 1'b0);
        check("sv_replay_addr", mem_word_addr, 8'd5);
        check("sv_stalled_rvalid", core_rvalid, 1'b0);
        @(negedge clk);
        check("sv_replay_rvalid", core_rvalid, 1'b1);
        check("sv_replay_rdata", core_rdata, 32'hDEADBEEF);
        check_rsp("sv_rsp");
`else
        // strict priority: ext waits for 20 core cycles, accepted once core drops
        core_drive(10'h014, 32'h0, 4'h0);
        ext_drive(1'b0, 10'h020, 32'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            #1;
            check("st_wait_ready", ext_req_ready, 1'b0);
            check("st_wait_stall", core_stall, 1'b0);
            @(negedge clk);
        end
        core_req = 1'b0;
        #1;
        check("st_accept_ready", ext_req_ready, 1'b1);
        check("st_accept_addr", mem_word_addr, 8'd8);
        exp_q.push_back(32'h00340078);
        @(negedge clk);
        ext_req_valid = 1'b0;
        @(negedge clk);
        check_rsp("st_rsp");
`endif
        core_req      = 1'b0;
        ext_rsp_ready = 1'b1;
        @(negedge clk);
        check("final_rsp_done", ext_rsp_valid, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);
        idle_inputs();
        @(negedge clk);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placed in front of the single-ported `data_memory` in the MEM stage. It shares the memory between the core load/store path (priority requester) and a secondary external bus port with valid/ready handshake, which is used for debug/DMA access. It drives the memory's word address, write data and byte enables each cycle, and routes the registered read data back to the requester that issued it.

## Interface
- `WIDTH`, 32: data word width in bits.
- `SIZE`, 256: memory depth in words; `LOGSIZE = $clog2(SIZE)`; byte address width `AW = LOGSIZE+2`.
- `NUM_COL`, 4: byte lanes (`WIDTH/8`).
- `STARVE_LIMIT`, 8: consecutive core-blocked cycles before the external requester is forced in (used only with `DMEM_ARB_STARVE_EN`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; resets all arbiter state.
- `core_req` in 1: core memory access this cycle.
- `core_addr` in AW: byte address; bits [1:0] are ignored.
- `core_wdata` in WIDTH: store data, already lane-aligned.
- `core_be` in NUM_COL: byte write enables; all zero means read.
- `core_stall` out 1: core access not performed this cycle; the core holds its request.
- `core_rvalid` out 1: `core_rdata` is valid (the core read was granted last cycle).
- `core_rdata` out WIDTH: memory read data for the core.
- `ext_req_valid` in 1, `ext_req_ready` out 1: external request handshake.
- `ext_we` in 1: 1 = write, 0 = read.
- `ext_addr` in AW: byte address; bits [1:0] are ignored.
- `ext_wdata` in WIDTH, `ext_wstrb` in NUM_COL: write data and byte strobes.
- `ext_rsp_valid` out 1, `ext_rsp_ready` in 1: response handshake.
- `ext_rdata` out WIDTH: read data; 0 for write responses.
- `mem_word_addr` out LOGSIZE, `mem_data_in` out WIDTH, `mem_byte_wr_en` out NUM_COL: drive `data_memory`.
- `mem_data_out` in WIDTH: registered memory output, valid one cycle after the address.

## Operation
- **Grant rule:**
  - `grant_ext = ext_fsm==EXT_IDLE && ext_req_valid && (!core_req || force_ext)`.
  - Otherwise the core owns the port when `core_req` is high.
  - `force_ext = (starve_cnt == STARVE_LIMIT)`.
- **Port mux:**
  - With the core granted: `mem_word_addr = core_addr[AW-1:2]`, `mem_data_in = core_wdata`, `mem_byte_wr_en = core_be`.
  - With external granted: the ext fields are used, with `mem_byte_wr_en = ext_we ? ext_wstrb : 0`.
  - With no grant: `mem_byte_wr_en = 0` and the address holds the core value.
- **Stall and handshake:**
  - `core_stall = core_req && grant_ext`, combinational.
  - `ext_req_ready = grant_ext`; at most one external transaction is outstanding.
- **Ext FSM:**
  - EXT_IDLE → EXT_ACCESS on accept.
  - EXT_ACCESS → EXT_RSP unconditionally. The response register loads `ext_we ? 0 : mem_data_out`.
  - EXT_RSP → EXT_IDLE on `ext_rsp_ready`.
  - `ext_rsp_valid` = (state == EXT_RSP).
  - `ext_rdata` is stable while valid and not ready.
- **Starvation counter:**
  - Increments when `ext_fsm==EXT_IDLE && ext_req_valid && core_req && !grant_ext`.
  - Saturates at STARVE_LIMIT and clears on external accept.
  - Clears when `ext_req_valid` drops while EXT_IDLE.
- **Core read return:**
  - `core_rvalid` is registered: `core_req && core_be==0 && !grant_ext`.
  - `core_rdata = mem_data_out`, passthrough.
- **Core write completion:** a core write completes in the grant cycle; no response is returned.

## Timing
- **Reset values:**
  - `ext_fsm` = EXT_IDLE, `starve_cnt` = 0.
  - `core_rvalid` = 0, `ext_rsp_valid` = 0, `ext_rdata` = 0.
  - Combinational outputs follow from these values.
- **Core read:** request in cycle T → data with `core_rvalid` in T+1.
- **External read:** accept at T → `ext_rsp_valid` at T+2 at the earliest. The response is held indefinitely under backpressure, and `ext_req_ready` stays 0 until the response handshake.
- **External write:** the memory is written at the T edge; the response arrives at T+2.
- **Simultaneous core and external request:**
  - The core wins unless `force_ext` is set.
  - A forced grant stalls the core for exactly 1 cycle, then the counter clears.
- **Reset mid-operation:** the FSM aborts to EXT_IDLE and a pending response is dropped. Writes already issued stay in memory.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: the starvation counter and `force_ext` are present, giving bounded external latency of ≤ STARVE_LIMIT+1 cycles to grant.
- Undefined: `force_ext` is tied to 0 and no counter is present. This gives strict core priority, and `core_stall` is constant 0.

## Structure
- **Package `dmem_arb_pkg`:**
  - `ext_state_t` enum {EXT_IDLE, EXT_ACCESS, EXT_RSP}.
  - `grant_t` enum {GNT_NONE, GNT_CORE, GNT_EXT}.
- **Sub-module `dmem_arb_starve_ctr`:** saturating counter with inputs `inc`, `clr` and output `sat`. It is instantiated only under `DMEM_ARB_STARVE_EN`.

## Test plan
- **Core read latency:** preload word 5 = 0xDEADBEEF; core read at addr 0x14 → `core_rvalid` = 1 with `core_rdata` = 0xDEADBEEF one cycle later.
- **External write then read:**
  - Ext write addr 0x20, data 0x12345678, strb 0b0101 over old 0 → `ext_rsp_valid` at T+2 with rdata 0.
  - A following ext read returns 0x00340078.
- **Contention, strict mode (macro undefined):** `core_req` held high for 20 cycles with `ext_req_valid` high → `ext_req_ready` stays 0 and is first accepted the cycle after `core_req` drops.
- **Starvation (macro defined, STARVE_LIMIT=8):** continuous core and ext requests → ext accepted in the 9th cycle, `core_stall` high for exactly that cycle, and the core access is replayed the next cycle.
- **Response backpressure:** hold `ext_rsp_ready` = 0 for 5 cycles → `ext_rdata` is stable, `ext_req_ready` = 0, and core accesses proceed unstalled.
- **Async reset in EXT_RSP:** `ext_rsp_valid` and `core_rvalid` drop immediately without a clock edge; after release, `ext_req_ready` = 1 on the first idle request.
